// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Includes the Moore decode used for the registered control outputs.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JAL    = 2'b10;

    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_B_FOUR = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       link;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic ctrl_t moore_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.pc_src  = PC_SRC_PLUS4;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALU_B_RS2;
                c.alu_op    = ALU_OP_FUNCT;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALU_B_IMM;
                c.alu_op    = ALU_OP_FUNCT;
            end
            S_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALU_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_WB_ALU: c.reg_write = 1'b1;
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALU_B_RS2;
                c.alu_op    = ALU_OP_SUB;
                c.pc_src    = PC_SRC_BRANCH;
            end
            S_JAL: begin
                c.reg_write = 1'b1;
                c.link      = 1'b1;
                c.pc_src    = PC_SRC_JAL;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Unified memory port between the control unit and the memory.
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts unanswered memory request cycles; saturates at LIMIT and flags expiry.
module mem_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(LIMIT));
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV64I-subset control FSM driving a shared ALU and one memory port.
// Moore controls are registered from the next state; FETCH/BRANCH strobes are Mealy.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 funct3,
    input  logic                       zero,
    multicycle_control_unit_if.master  mem,
    output logic                       ir_write,
    output logic                       pc_write,
    output logic [1:0]                 pc_src,
    output logic                       reg_write,
    output logic                       mem_to_reg,
    output logic                       link,
    output logic                       alu_src_a,
    output logic [1:0]                 alu_src_b,
    output logic [1:0]                 alu_op,
    output logic [3:0]                 state_o,
    output logic [CNT_W-1:0]           instret,
    output logic                       illegal_instr,
    output logic                       bus_error
);

    if (XLEN < 32 || MEM_TIMEOUT < 1) begin : g_param_check
        $error("multicycle_control_unit: XLEN must be >= 32 and MEM_TIMEOUT >= 1");
    end

    state_t           state;
    state_t           state_next;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_o;
    logic [CNT_W-1:0] instret_q;
    logic             bus_error_q;
    logic             mem_done;
    logic             expired;
    logic             retire;
    logic             illegal;
    logic             ir_write_c;
    logic             pc_write_c;
    logic             timeout_hit;
    logic             tmo_clear;
    logic             tmo_enable;

    // A ready with no outstanding request must never advance the FSM.
    assign mem_done = mem.mem_ready & ctrl_q.mem_req;

    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        illegal     = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_done) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_next = S_DECODE;
                end else if (expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_next = S_EXEC_R;
                    OP_I:               state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = S_ADDR;
                    OP_BRANCH:          state_next = S_BRANCH;
                    OP_JAL:             state_next = S_JAL;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
            S_ADDR: state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_done) begin
                    state_next = S_WB_MEM;
                end else if (expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_MEM_WR: begin
                if (mem_done) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_WB_ALU, S_WB_MEM: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                state_next = S_FETCH;
                case (funct3)
                    F3_BEQ: begin
                        pc_write_c = zero;
                        retire     = 1'b1;
                    end
                    F3_BNE: begin
                        pc_write_c = ~zero;
                        retire     = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            S_JAL: begin
                pc_write_c = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    assign tmo_clear  = (state_next != state) &&
                        (state_next inside {S_FETCH, S_MEM_RD, S_MEM_WR});
    assign tmo_enable = ctrl_q.mem_req & ~mem.mem_ready;

    mem_timeout_counter #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            ctrl_q      <= moore_decode(S_FETCH);
            instret_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state  <= state_next;
            ctrl_q <= moore_decode(state_next);
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (timeout_hit) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    // Every strobe is forced low while reset is asserted.
    assign ctrl_o = reset ? '0 : ctrl_q;

    assign mem.mem_req    = ctrl_o.mem_req;
    assign mem.mem_we     = ctrl_o.mem_we;
    assign mem.iord       = ctrl_o.iord;
    assign reg_write      = ctrl_o.reg_write;
    assign mem_to_reg     = ctrl_o.mem_to_reg;
    assign link           = ctrl_o.link;
    assign alu_src_a      = ctrl_o.alu_src_a;
    assign alu_src_b      = ctrl_o.alu_src_b;
    assign alu_op         = ctrl_o.alu_op;
    assign pc_src         = ctrl_o.pc_src;
    assign ir_write       = ir_write_c & ~reset;
    assign pc_write       = pc_write_c & ~reset;
    assign illegal_instr  = illegal & ~reset;
    assign state_o        = state;
    assign instret        = instret_q;
    assign bus_error      = bus_error_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM; successor to the single-cycle Control_Unit.
- Sequences one RV64I subset instruction over several cycles through a shared ALU and a single unified memory port with a req/ready handshake.
- Adds wait-state tolerance, a memory timeout, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register, regfile/ALU datapath and the memory port of the multi-cycle processor top.

Parameters:
- XLEN, 64, datapath width; informational only, used for pc_src/alu encodings documentation.
- MEM_TIMEOUT, 16, cycles a memory request may wait for mem_ready before bus_error; must be >= 1.
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  1=write (store), 0=read
- iord  out  1  0=address from PC, 1=address from ALUOut
- ir_write  out  1  latch memory data into IR
- pc_write  out  1  update PC this cycle
- pc_src  out  2  00 PC+4, 01 branch target, 10 JAL target
- reg_write  out  1  regfile write enable
- mem_to_reg  out  1  1=MDR to rd, 0=ALUOut (or PC+4 for JAL via link)
- link  out  1  write old PC+4 to rd (JAL)
- alu_src_a  out  1  0=PC, 1=rs1
- alu_src_b  out  2  00 rs2, 01 immediate, 10 const 4
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- state_o  out  4  current state encoding (debug)
- instret  out  CNT_W  retired instruction count, wraps to 0 at max
- illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct3
- bus_error  out  1  sticky until reset

Behaviour:
- Reset (synchronous, active-high): state=FETCH, instret=0, timeout counter=0, bus_error=0. All strobes are low in the reset cycle. Reset has priority in any state, including mid-wait.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, HALT.
- FETCH: mem_req=1, mem_we=0, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise stay.
- DECODE: decode opcode. 0110011→EXEC_R; 0010011→EXEC_I; 0000011/0100011→ADDR; 1100011→BRANCH; 1101111→JAL. Any other opcode: illegal_instr=1, go to FETCH; not counted in instret.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=01, alu_op=10, then WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, instret++, then FETCH.
- ADDR: alu_src_a=1, alu_src_b=01, alu_op=00. Load goes to MEM_RD; store goes to MEM_WR.
- MEM_RD: mem_req=1, iord=1. On mem_ready go to WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, instret++, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready: instret++, go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01.
  - funct3=000 (beq): pc_write=zero.
  - funct3=001 (bne): pc_write=!zero.
  - pc_src=01 in both cases; instret++, then FETCH.
  - Other funct3: illegal_instr=1, no pc_write, go to FETCH.
- JAL: reg_write=1, link=1, pc_write=1, pc_src=10, instret++, then FETCH.
- Latency with zero wait states (mem_ready in the first request cycle), in cycles: R/I 4, load 5, store 4, branch 3, JAL 3. Each wait cycle adds 1.
- Handshake:
  - mem_req, mem_we and iord stay stable until the mem_ready cycle.
  - mem_ready while mem_req=0 is ignored.
  - ir_write and pc_write in FETCH are Mealy outputs, gated by mem_ready. All other outputs are Moore.
- Timeout:
  - The counter clears on entering FETCH, MEM_RD or MEM_WR, and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still low: bus_error←1, go to HALT.
  - mem_ready in the same cycle as the count reaching MEM_TIMEOUT wins: normal completion.
- HALT: all strobes 0; remain until reset.
- instret wraps from 2^CNT_W−1 to 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state typedef (4-bit enum);
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL;
  - pc_src, alu_src_b and alu_op encodings.
- One natural sub-module: mem_timeout_counter (clear, count enable, expired flag).

Test Plan:
- add x3,x1,x2 (opcode 0110011), mem_ready always 1 → states FETCH,DECODE,EXEC_R,WB_ALU; reg_write in cycle 4; instret 0→1.
- lw with mem_ready delayed 3 cycles in MEM_RD → mem_req/iord=1 held 4 cycles; WB_MEM with mem_to_reg=1 in cycle 8; instret=1.
- beq with zero=1, then bne with zero=1 → pc_write=1 pc_src=01 for the first, pc_write=0 for the second; each 3 cycles.
- opcode 1111111 → illegal_instr one-cycle pulse in DECODE, back to FETCH; instret unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → bus_error=1 after 4 waiting cycles, state_o=HALT, strobes 0 until reset.
- Reset asserted mid-MEM_WR wait → next cycle state=FETCH, instret=0, mem_req=1 (fetch), mem_we=0.
